// File: rtl/wash_phase_timer.sv
// Sensor/timer stage for the washing machine controller: wash and spin
// phase timers plus a saturating water-level model driven by the valve commands.
module wash_phase_timer #(
    parameter int unsigned WASH_CYCLES = 20,
    parameter int unsigned SPIN_CYCLES = 12,
    parameter int unsigned LEVEL_MAX   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fill_value_on,
    input  logic       drain_value_on,
    input  logic       motor_on,
    input  logic       soap_wash,
    input  logic       water_wash,
    output logic       filled,
    output logic       drained,
    output logic       cycle_timeout,
    output logic       spin_timeout,
    output logic [3:0] level,
    output logic       valve_conflict
);

    localparam logic [7:0] WASH_LAST = 8'(WASH_CYCLES - 1);
    localparam logic [7:0] SPIN_LAST = 8'(SPIN_CYCLES - 1);
    localparam logic [3:0] LVL_FULL  = 4'(LEVEL_MAX);

    logic       wash_act;
    logic       spin_act;
    logic [1:0] kind_in;

    logic [1:0] wash_kind_q;
    logic [7:0] wash_cnt_q, wash_cnt_d;
    logic       cto_q, cto_d;
    logic [7:0] spin_cnt_q, spin_cnt_d;
    logic       sto_q, sto_d;
    logic [3:0] level_q, level_d;
    logic       filled_q, drained_q;
    logic       conflict_q, conflict_d;

    assign wash_act = motor_on & ~drain_value_on & ~fill_value_on;
    assign spin_act = motor_on & drain_value_on;
    assign kind_in  = {soap_wash, water_wash};

    // Wash timer: a change of wash kind restarts the count with the switch edge as edge 1.
    always_comb begin
        wash_cnt_d = wash_cnt_q;
        cto_d      = cto_q;
        if (!wash_act) begin
            wash_cnt_d = '0;
            cto_d      = 1'b0;
        end else if (kind_in != wash_kind_q) begin
            wash_cnt_d = 8'd1;
            cto_d      = 1'b0;
        end else if (!cto_q) begin
            wash_cnt_d = wash_cnt_q + 8'd1;
            cto_d      = (wash_cnt_q == WASH_LAST);
        end
    end

    always_comb begin
        spin_cnt_d = spin_cnt_q;
        sto_d      = sto_q;
        if (!spin_act) begin
            spin_cnt_d = '0;
            sto_d      = 1'b0;
        end else if (!sto_q) begin
            spin_cnt_d = spin_cnt_q + 8'd1;
            sto_d      = (spin_cnt_q == SPIN_LAST);
        end
    end

    // Both valves open is a fault: level is frozen and the flag latches until reset.
    always_comb begin
        level_d    = level_q;
        conflict_d = conflict_q;
        if (fill_value_on && drain_value_on) begin
            conflict_d = 1'b1;
        end else if (fill_value_on && (level_q < LVL_FULL)) begin
            level_d = level_q + 4'd1;
        end else if (drain_value_on && (level_q != 4'd0)) begin
            level_d = level_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wash_kind_q <= '0;
            wash_cnt_q  <= '0;
            cto_q       <= 1'b0;
            spin_cnt_q  <= '0;
            sto_q       <= 1'b0;
            level_q     <= '0;
            filled_q    <= 1'b0;
            drained_q   <= 1'b1;
            conflict_q  <= 1'b0;
        end else begin
            wash_kind_q <= kind_in;
            wash_cnt_q  <= wash_cnt_d;
            cto_q       <= cto_d;
            spin_cnt_q  <= spin_cnt_d;
            sto_q       <= sto_d;
            level_q     <= level_d;
            filled_q    <= (level_d == LVL_FULL);
            drained_q   <= (level_d == 4'd0);
            conflict_q  <= conflict_d;
        end
    end

    assign filled         = filled_q;
    assign drained        = drained_q;
    assign cycle_timeout  = cto_q;
    assign spin_timeout   = sto_q;
    assign level          = level_q;
    assign valve_conflict = conflict_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Self-checking bench for wash_phase_timer: vector table, directed timing
// sequences and randomized phases checked against a run-length reference model.
module tb_wash_phase_timer;

    localparam int WASH = 20;
    localparam int SPIN = 12;
    localparam int LMAX = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       fill_value_on = 1'b0, drain_value_on = 1'b0, motor_on = 1'b0;
    logic       soap_wash = 1'b0, water_wash = 1'b0;
    logic       filled, drained, cycle_timeout, spin_timeout, valve_conflict;
    logic [3:0] level;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: run lengths of consecutive active edges.
    int m_level = 0, m_wrun = 0, m_srun = 0;
    bit m_conf = 0;
    bit [1:0] m_kind = 2'b00;

    always #5 clk = ~clk;

    wash_phase_timer #(
        .WASH_CYCLES(WASH),
        .SPIN_CYCLES(SPIN),
        .LEVEL_MAX  (LMAX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fill_value_on (fill_value_on),
        .drain_value_on(drain_value_on),
        .motor_on      (motor_on),
        .soap_wash     (soap_wash),
        .water_wash    (water_wash),
        .filled        (filled),
        .drained       (drained),
        .cycle_timeout (cycle_timeout),
        .spin_timeout  (spin_timeout),
        .level         (level),
        .valve_conflict(valve_conflict)
    );

    typedef struct {
        bit rst, fill, drain, motor, soap, water;
        bit e_filled, e_drained, e_cto, e_sto;
        int e_level;
        bit e_vc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit f, input bit d, input bit m, input bit s, input bit w);
        reset = r; fill_value_on = f; drain_value_on = d;
        motor_on = m; soap_wash = s; water_wash = w;
    endtask

    task automatic model_edge();
        bit wa, sa;
        if (reset) begin
            m_level = 0; m_conf = 0; m_wrun = 0; m_srun = 0; m_kind = 2'b00;
        end else begin
            wa = motor_on && !drain_value_on && !fill_value_on;
            sa = motor_on && drain_value_on;
            if (!wa) m_wrun = 0;
            else if ({soap_wash, water_wash} != m_kind) m_wrun = 1;
            else m_wrun++;
            m_kind = {soap_wash, water_wash};
            m_srun = sa ? m_srun + 1 : 0;
            if (fill_value_on && drain_value_on) m_conf = 1;
            else if (fill_value_on && m_level < LMAX) m_level++;
            else if (drain_value_on && m_level > 0) m_level--;
        end
    endtask

    task automatic check_model();
        chk("level",          int'(level),          m_level);
        chk("filled",         int'(filled),         int'(m_level == LMAX));
        chk("drained",        int'(drained),        int'(m_level == 0));
        chk("cycle_timeout",  int'(cycle_timeout),  int'(m_wrun >= WASH));
        chk("spin_timeout",   int'(spin_timeout),   int'(m_srun >= SPIN));
        chk("valve_conflict", int'(valve_conflict), int'(m_conf));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    function automatic bit out_of(input int w);
        case (w)
            0: return filled;
            1: return drained;
            2: return cycle_timeout;
            default: return spin_timeout;
        endcase
    endfunction

    // Ticks until the selected output reaches val; checks how many edges that took.
    task automatic edges_until(input string name, input int w, input bit val, input int exp_n);
        int n = 0;
        do begin
            tick();
            n++;
        end while (out_of(w) != val && n < 3 * exp_n + 10);
        chk(name, n, exp_n);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    function automatic vec_t mk(input bit r, f, d, m, s, w, ef, ed, ec, es, input int el, input bit ev);
        vec_t v;
        v.rst = r; v.fill = f; v.drain = d; v.motor = m; v.soap = s; v.water = w;
        v.e_filled = ef; v.e_drained = ed; v.e_cto = ec; v.e_sto = es;
        v.e_level = el; v.e_vc = ev;
        return v;
    endfunction

    initial begin
        // Fill from empty, saturate, drain once, conflict, reset.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(0, 1, 0, 0, 0, 0, (i == 8), 0, 0, 0, i, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 7, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 7, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        #2;
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].fill, tbl[i].drain, tbl[i].motor, tbl[i].soap, tbl[i].water);
            tick();
            chk("tbl_level",    int'(level),          tbl[i].e_level);
            chk("tbl_filled",   int'(filled),         int'(tbl[i].e_filled));
            chk("tbl_drained",  int'(drained),        int'(tbl[i].e_drained));
            chk("tbl_cto",      int'(cycle_timeout),  int'(tbl[i].e_cto));
            chk("tbl_sto",      int'(spin_timeout),   int'(tbl[i].e_sto));
            chk("tbl_conflict", int'(valve_conflict), int'(tbl[i].e_vc));
        end

        // Wash timeout: rises on the 20th active edge, holds, drops one edge after motor off.
        do_reset();
        drive(0, 1, 0, 0, 0, 0);
        repeat (8) tick();
        drive(0, 0, 0, 1, 1, 0);
        edges_until("wash_timeout_edges", 2, 1'b1, WASH);
        repeat (5) begin
            tick();
            chk("wash_timeout_hold", int'(cycle_timeout), 1);
        end
        drive(0, 0, 0, 0, 1, 0);
        tick();
        chk("wash_timeout_drop", int'(cycle_timeout), 0);

        // Kind switch after 10 edges restarts the count from the switch edge.
        drive(0, 0, 0, 1, 1, 0);
        repeat (10) tick();
        drive(0, 0, 0, 1, 0, 1);
        edges_until("wash_switch_edges", 2, 1'b1, WASH);

        // Spin from full: drained at edge 8, spin_timeout at edge 12, no wash timeout.
        do_reset();
        drive(0, 1, 0, 0, 0, 0);
        repeat (8) tick();
        chk("spin_pre_full", int'(filled), 1);
        drive(0, 0, 1, 1, 0, 0);
        edges_until("spin_drained_edges", 1, 1'b1, LMAX);
        edges_until("spin_timeout_edges", 3, 1'b1, SPIN - LMAX);
        chk("spin_no_cto", int'(cycle_timeout), 0);

        // Valve conflict at level 3 is sticky until reset.
        do_reset();
        drive(0, 1, 0, 0, 0, 0);
        repeat (3) tick();
        drive(0, 1, 1, 0, 0, 0);
        tick();
        chk("conflict_level", int'(level), 3);
        chk("conflict_set", int'(valve_conflict), 1);
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("conflict_sticky", int'(valve_conflict), 1);
        do_reset();
        chk("conflict_cleared", int'(valve_conflict), 0);

        // Reset mid-spin at count 7, then spin again for a full 12 edges.
        drive(0, 1, 0, 0, 0, 0);
        repeat (5) tick();
        drive(0, 0, 1, 1, 0, 0);
        repeat (7) tick();
        drive(1, 0, 1, 1, 0, 0);
        tick();
        chk("rst_spin_level",   int'(level),        0);
        chk("rst_spin_drained", int'(drained),      1);
        chk("rst_spin_sto",     int'(spin_timeout), 0);
        drive(0, 0, 1, 1, 0, 0);
        edges_until("rst_spin_timeout_edges", 3, 1'b1, SPIN);

        // Randomized phases held for random lengths.
        for (int p = 0; p < 150; p++) begin
            int len = $urandom_range(1, 30);
            case ($urandom_range(0, 7))
                0: drive(0, 0, 0, 0, 0, 0);
                1: drive(0, 1, 0, 0, 0, 0);
                2: drive(0, 0, 1, 0, 0, 0);
                3: drive(0, 0, 0, 1, 1, 0);
                4: drive(0, 0, 0, 1, 0, 1);
                5: drive(0, 0, 1, 1, 0, 0);
                6: drive(0, 1, 1, $urandom_range(0, 1), 0, 0);
                default: drive(0, $urandom_range(0, 1), $urandom_range(0, 1),
                               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            endcase
            if ($urandom_range(0, 15) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            repeat (len) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wash_phase_timer.md
# wash_phase_timer

Upstream sensor/timer stage for the washing machine controller. It watches the controller's actuator outputs (fill_value_on, drain_value_on, motor_on, soap_wash, water_wash) and generates the controller's status inputs: filled, drained, cycle_timeout and spin_timeout. It contains a wash-phase timer, a spin-phase timer and a water-level model. This lets the controller run closed-loop in simulation and on the board without external stimulus.

## Interface

Parameters:
- WASH_CYCLES, default 20: clock edges of wash phase before cycle_timeout; legal range 2..255.
- SPIN_CYCLES, default 12: clock edges of spin phase before spin_timeout; legal range 2..255.
- LEVEL_MAX, default 8: water-level steps from empty to full; legal range 1..15.

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- fill_value_on, input, 1: controller fill valve command.
- drain_value_on, input, 1: controller drain valve command.
- motor_on, input, 1: controller drum motor command.
- soap_wash, input, 1: controller in soap-wash phase.
- water_wash, input, 1: controller in rinse phase.
- filled, output, 1: registered; level == LEVEL_MAX.
- drained, output, 1: registered; level == 0.
- cycle_timeout, output, 1: registered; wash phase time elapsed.
- spin_timeout, output, 1: registered; spin phase time elapsed.
- level, output, 4: registered current water level.
- valve_conflict, output, 1: registered; sticky fault flag.

## Operation

Phase decode (combinational, sampled each edge):
- wash_act = motor_on & ~drain_value_on & ~fill_value_on.
- spin_act = motor_on & drain_value_on.
- wash_act and spin_act are mutually exclusive by construction.

Wash timer: 8-bit wash_cnt, plus a 2-bit wash_kind register holding {soap_wash, water_wash} as sampled on the previous edge.
- Edge with wash_act=0: wash_cnt<=0, cycle_timeout<=0.
- Edge with wash_act=1 and {soap_wash, water_wash} != wash_kind (a phase switch): wash_cnt<=1, cycle_timeout<=0. The switch edge counts as the first active edge.
- Edge with wash_act=1, no switch, cycle_timeout=0:
  - wash_cnt<=wash_cnt+1.
  - If wash_cnt == WASH_CYCLES-1, also cycle_timeout<=1.
- Edge with wash_act=1 and cycle_timeout=1: hold. cycle_timeout stays level-high until wash_act drops.
- wash_kind<={soap_wash, water_wash} on every edge.

Spin timer: 8-bit spin_cnt driving spin_timeout, same rules keyed on spin_act. There is no kind-switch rule.

Level model:
- fill_value_on=1, drain_value_on=0, level<LEVEL_MAX: level<=level+1.
- drain_value_on=1, fill_value_on=0, level>0: level<=level-1.
- Both valves 1: level holds, and valve_conflict<=1. valve_conflict clears only on reset.
- Otherwise level holds. It saturates at 0 and at LEVEL_MAX, with no wrap-around.
- filled and drained are registered and decoded from next-state level, so they change on the same edge as level.

Reset (synchronous):
- level=0, filled=0, drained=1, cycle_timeout=0, spin_timeout=0, valve_conflict=0.
- wash_cnt=0, spin_cnt=0, wash_kind=2'b00.
- Reset asserted mid-phase overrides all counting at that edge. Counting restarts from the first post-reset edge at which a phase is active.

## Timing

Wash/spin timing:
- If wash_act is continuously 1 from edge k (first sampled edge), cycle_timeout is 1 after edge k+WASH_CYCLES-1. That is the WASH_CYCLES-th active edge.
- spin_timeout follows the same rule with SPIN_CYCLES.
- Timeouts fall on the first edge at which the phase is sampled inactive: one-cycle latency.
- A one-cycle drop of wash_act fully restarts the count.

Level timing:
- A fill from empty asserts filled after exactly LEVEL_MAX edges with fill-only.
- drained deasserts on the first fill edge.
- A drain from full asserts drained after LEVEL_MAX drain-only edges.
- filled deasserts on the first drain edge.

Simultaneous events:
- Reset wins over everything.
- Valve conflict wins over level change.
- spin_act with fill_value_on=1 still counts spin and also flags conflict.

There is no combinational path from input to output.

## Test plan

- Reset, then fill_value_on=1 only with LEVEL_MAX=8 -> drained falls at edge 1, level=8 and filled=1 at edge 8, level stays 8 on further edges.
- Full tank, then motor_on=1 and soap_wash=1 with WASH_CYCLES=20 -> cycle_timeout=1 after the 20th edge, held while active, 0 one edge after motor_on drops.
- Wash active for 10 edges with soap_wash, then switch to water_wash (motor still on) -> the count restarts, and cycle_timeout rises 20 edges after the switch edge, not 10.
- motor_on=1 and drain_value_on=1 from level=8 with SPIN_CYCLES=12 -> drained=1 after edge 8, spin_timeout=1 after edge 12, cycle_timeout stays 0 throughout.
- fill_value_on=1 and drain_value_on=1 at level=3 -> level holds at 3, valve_conflict=1 and stays 1 after the valves clear, until reset.
- Reset asserted for one edge during spin with spin_cnt=7 -> all outputs return to reset values (drained=1, level=0). With spin still active after reset, spin_timeout rises 12 edges later.
